// File: rtl/resize_pyramid_scheduler_if.sv
// Bundle of the frame-controller, resize and scale-cache consumer signals
// around resize_pyramid_scheduler; master is the scheduler side.
interface resize_pyramid_scheduler_if #(
  parameter int ROW_BITS   = 10,
  parameter int COL_BITS   = 10,
  parameter int FIXED_BITS = 16,
  parameter int MAX_LEVELS = 16
);
  localparam int LVL_BITS = $clog2(MAX_LEVELS) + 1;
  localparam int IDX_BITS = $clog2(MAX_LEVELS);

  logic                  cfg_start;
  logic [ROW_BITS-1:0]   cfg_image_x_size;
  logic [COL_BITS-1:0]   cfg_image_y_size;
  logic [FIXED_BITS-1:0] cfg_step;
  logic [FIXED_BITS-1:0] cfg_inv_step;
  logic                  cfg_ready;
  logic                  cfg_done;
  logic                  cfg_taken;
  logic [LVL_BITS-1:0]   cfg_levels;

  logic                  rs_start;
  logic                  rs_taken;
  logic                  rs_ready;
  logic                  rs_done;
  logic [ROW_BITS-1:0]   rs_image_x_size;
  logic [COL_BITS-1:0]   rs_image_y_size;
  logic [ROW_BITS-1:0]   rs_target_x_size;
  logic [COL_BITS-1:0]   rs_target_y_size;
  logic [FIXED_BITS-1:0] rs_factor_x;
  logic [FIXED_BITS-1:0] rs_factor_y;

  logic                  lvl_valid;
  logic [IDX_BITS-1:0]   lvl_index;
  logic                  lvl_ack;

  logic [31:0]           perf_cycles;

  modport master (
    input  cfg_start, cfg_image_x_size, cfg_image_y_size, cfg_step, cfg_inv_step,
           cfg_taken, rs_ready, rs_done, lvl_ack,
    output cfg_ready, cfg_done, cfg_levels, rs_start, rs_taken,
           rs_image_x_size, rs_image_y_size, rs_target_x_size, rs_target_y_size,
           rs_factor_x, rs_factor_y, lvl_valid, lvl_index, perf_cycles
  );

  modport slave (
    output cfg_start, cfg_image_x_size, cfg_image_y_size, cfg_step, cfg_inv_step,
           cfg_taken, rs_ready, rs_done, lvl_ack,
    input  cfg_ready, cfg_done, cfg_levels, rs_start, rs_taken,
           rs_image_x_size, rs_image_y_size, rs_target_x_size, rs_target_y_size,
           rs_factor_x, rs_factor_y, lvl_valid, lvl_index, perf_cycles
  );
endinterface

// File: rtl/resize_pyramid_scheduler.sv
// Walks one source frame through every pyramid level: size/factor update, resize pass, consumer hand-off.
// Optional frame cycle counter on perf_cycles when RESIZE_PYRAMID_PERF_EN is defined.
module resize_pyramid_scheduler #(
  parameter int ROW_BITS   = 10,
  parameter int COL_BITS   = 10,
  parameter int FIXED_BITS = 16,
  parameter int FRAC_BITS  = 8,
  parameter int MAX_LEVELS = 16,
  parameter int MIN_X      = 24,
  parameter int MIN_Y      = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  resize_pyramid_scheduler_if.master    bus
);
  localparam int LVL_BITS = $clog2(MAX_LEVELS) + 1;
  localparam int IDX_BITS = $clog2(MAX_LEVELS);
  localparam logic [FIXED_BITS-1:0] FIX_ONE = {{(FIXED_BITS-1){1'b0}}, 1'b1} << FRAC_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_TAKE, S_NOTIFY, S_NEXT, S_DONE
  } state_t;

  state_t                state, state_next;
  logic                  armed;
  logic                  accept;
  logic                  stop;
  logic                  ready;
  logic [ROW_BITS-1:0]   img_x,  tgt_x;
  logic [COL_BITS-1:0]   img_y,  tgt_y;
  logic [FIXED_BITS-1:0] step,   inv_step, factor;
  logic [LVL_BITS-1:0]   level,  levels_done;

  // Truncating size update: full-width product, drop the fraction, keep the low size bits.
  function automatic logic [ROW_BITS-1:0] scale_x(input logic [ROW_BITS-1:0] size,
                                                  input logic [FIXED_BITS-1:0] mul);
    logic [ROW_BITS+FIXED_BITS-1:0] prod;
    prod = {{FIXED_BITS{1'b0}}, size} * {{ROW_BITS{1'b0}}, mul};
    return prod[FRAC_BITS +: ROW_BITS];
  endfunction

  function automatic logic [COL_BITS-1:0] scale_y(input logic [COL_BITS-1:0] size,
                                                  input logic [FIXED_BITS-1:0] mul);
    logic [COL_BITS+FIXED_BITS-1:0] prod;
    prod = {{FIXED_BITS{1'b0}}, size} * {{COL_BITS{1'b0}}, mul};
    return prod[FRAC_BITS +: COL_BITS];
  endfunction

  // Factor grows each level, so clamp to all-ones instead of wrapping.
  function automatic logic [FIXED_BITS-1:0] scale_factor(input logic [FIXED_BITS-1:0] f,
                                                         input logic [FIXED_BITS-1:0] s);
    logic [2*FIXED_BITS-1:0] prod;
    prod = {{FIXED_BITS{1'b0}}, f} * {{FIXED_BITS{1'b0}}, s};
    if (|prod[2*FIXED_BITS-1:FIXED_BITS+FRAC_BITS])
      return '1;
    return prod[FRAC_BITS +: FIXED_BITS];
  endfunction

  assign accept = (state == S_IDLE) && armed && bus.cfg_start;
  assign stop   = (tgt_x < ROW_BITS'(MIN_X)) || (tgt_y < COL_BITS'(MIN_Y)) ||
                  (level == LVL_BITS'(MAX_LEVELS)) ||
                  ((level != '0) && (inv_step >= FIX_ONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    ready         = 1'b0;
    bus.cfg_done  = 1'b0;
    bus.rs_start  = 1'b0;
    bus.rs_taken  = 1'b0;
    bus.lvl_valid = 1'b0;
    case (state)
      S_IDLE: begin
        ready = armed;
        if (accept) state_next = S_CHECK;
      end
      S_CHECK:  state_next = stop ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        bus.rs_start = 1'b1;
        if (bus.rs_ready) state_next = S_WAIT;
      end
      S_WAIT:   if (bus.rs_done) state_next = S_TAKE;
      S_TAKE: begin
        bus.rs_taken = 1'b1;
        state_next   = S_NOTIFY;
      end
      // Scale cache is single-buffered: the next pass waits for the consumer.
      S_NOTIFY: begin
        bus.lvl_valid = 1'b1;
        if (bus.lvl_ack) state_next = S_NEXT;
      end
      S_NEXT:   state_next = S_CHECK;
      S_DONE: begin
        bus.cfg_done = 1'b1;
        if (bus.cfg_taken) state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed       <= 1'b0;
      img_x       <= '0;
      img_y       <= '0;
      step        <= '0;
      inv_step    <= '0;
      tgt_x       <= '0;
      tgt_y       <= '0;
      factor      <= '0;
      level       <= '0;
      levels_done <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        S_IDLE: if (accept) begin
          img_x       <= bus.cfg_image_x_size;
          img_y       <= bus.cfg_image_y_size;
          step        <= bus.cfg_step;
          inv_step    <= bus.cfg_inv_step;
          tgt_x       <= bus.cfg_image_x_size;
          tgt_y       <= bus.cfg_image_y_size;
          factor      <= FIX_ONE;
          level       <= '0;
          levels_done <= '0;
        end
        S_TAKE: levels_done <= levels_done + LVL_BITS'(1);
        S_NEXT: begin
          tgt_x  <= scale_x(tgt_x, inv_step);
          tgt_y  <= scale_y(tgt_y, inv_step);
          factor <= scale_factor(factor, step);
          level  <= level + LVL_BITS'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.cfg_ready        = ready;
  assign bus.cfg_levels       = levels_done;
  assign bus.rs_image_x_size  = img_x;
  assign bus.rs_image_y_size  = img_y;
  assign bus.rs_target_x_size = tgt_x;
  assign bus.rs_target_y_size = tgt_y;
  assign bus.rs_factor_x      = factor;
  assign bus.rs_factor_y      = factor;
  assign bus.lvl_index        = level[IDX_BITS-1:0];

`ifdef RESIZE_PYRAMID_PERF_EN
  logic [31:0] perf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       perf <= '0;
    else if (accept)                                 perf <= '0;
    else if ((state != S_IDLE) && (state != S_DONE)) perf <= perf + 32'd1;
  end

  assign bus.perf_cycles = perf;
`else
  assign bus.perf_cycles = '0;
`endif
endmodule

// File: tb/tb_resize_pyramid_scheduler.sv
// Frame-table bench for resize_pyramid_scheduler: expected resize passes queued per frame,
// checked at every rs_start handshake, plus hand-written ack-stall and mid-frame reset sequences.
module tb_resize_pyramid_scheduler;
  localparam int ROW_BITS = 10, COL_BITS = 10, FIXED_BITS = 16, FRAC_BITS = 8;
  localparam int MAX_LEVELS = 16, MIN_X = 24, MIN_Y = 24;

  logic clk = 1'b0;
  logic reset = 1'b1;

  resize_pyramid_scheduler_if #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS),
                                .FIXED_BITS(FIXED_BITS), .MAX_LEVELS(MAX_LEVELS)) bus ();

  resize_pyramid_scheduler #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .FIXED_BITS(FIXED_BITS),
                             .FRAC_BITS(FRAC_BITS), .MAX_LEVELS(MAX_LEVELS),
                             .MIN_X(MIN_X), .MIN_Y(MIN_Y)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    int x; int y; int step; int inv; int levels;
    int last_x; int last_y; int last_f; int delay; int stall;
  } frame_t;
  typedef struct { int x; int y; int f; int lvl; } pass_t;

  frame_t frames[7];
  pass_t  exp_q[$];
  int checks = 0, errors = 0;
  int done_delay = 2, stall_len = 0;
  int hold_level = -1, hold_len = 0, hold_x = 0, hold_y = 0;
  int passes = 0, taken = 0, last_x = 0, last_y = 0, last_f = 0;
  int cur_img_x = 0, cur_img_y = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_model(input frame_t fr);
    longint tx, ty, f;
    int lvl;
    pass_t p;
    tx = fr.x; ty = fr.y; f = 256; lvl = 0;
    while (!(tx < MIN_X || ty < MIN_Y || lvl == MAX_LEVELS || (lvl > 0 && fr.inv >= 256))) begin
      p = '{int'(tx), int'(ty), int'(f), lvl};
      exp_q.push_back(p);
      tx = ((tx * fr.inv) >> 8) % 1024;
      ty = ((ty * fr.inv) >> 8) % 1024;
      f  = (f * fr.step) >> 8;
      if (f > 65535) f = 65535;
      lvl++;
    end
  endtask

  task automatic check_pass();
    pass_t p;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_rs_start: got pass %0d, expected none", passes);
    end else begin
      p = exp_q.pop_front();
      check("target_x", bus.rs_target_x_size, p.x);
      check("target_y", bus.rs_target_y_size, p.y);
      check("factor_x", bus.rs_factor_x, p.f);
      check("factor_y", bus.rs_factor_y, p.f);
      check("pass_level", bus.lvl_index, p.lvl);
      check("image_x", bus.rs_image_x_size, cur_img_x);
      check("image_y", bus.rs_image_y_size, cur_img_y);
    end
    passes++;
    last_x = int'(bus.rs_target_x_size);
    last_y = int'(bus.rs_target_y_size);
    last_f = int'(bus.rs_factor_x);
  endtask

  // Resize model plus pass monitor
  initial begin
    int cnt, stall_cnt;
    bit pending;
    cnt = 0; stall_cnt = 0; pending = 0;
    bus.rs_ready = 1'b1;
    bus.rs_done  = 1'b0;
    forever begin
      @(negedge clk);
      bus.rs_done = 1'b0;
      if (reset) begin
        pending = 0; cnt = 0; stall_cnt = 0; bus.rs_ready = 1'b1;
      end else begin
        if (bus.rs_taken) taken++;
        if (pending) begin
          if (cnt <= 1) begin bus.rs_done = 1'b1; pending = 0; end
          else cnt--;
        end else if (bus.rs_start) begin
          if (stall_cnt < stall_len) begin
            bus.rs_ready = 1'b0; stall_cnt++;
          end else begin
            bus.rs_ready = 1'b1; stall_cnt = 0; pending = 1; cnt = done_delay;
            check_pass();
          end
        end
      end
    end
  end

  // Level consumer
  initial begin
    int hold_cnt;
    hold_cnt = 0;
    bus.lvl_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.lvl_valid && !reset) begin
        if (hold_level == int'(bus.lvl_index) && hold_cnt < hold_len) begin
          bus.lvl_ack = 1'b0;
          hold_cnt++;
          check("hold_rs_start", bus.rs_start, 0);
          if (hold_cnt == hold_len) begin
            check("hold_lvl_valid", bus.lvl_valid, 1);
            check("hold_lvl_index", bus.lvl_index, hold_level);
            check("hold_target_x", bus.rs_target_x_size, hold_x);
            check("hold_target_y", bus.rs_target_y_size, hold_y);
          end
        end else begin
          bus.lvl_ack = 1'b1;
        end
      end else begin
        bus.lvl_ack = 1'b0;
        if (hold_level < 0) hold_cnt = 0;
      end
    end
  end

  task automatic start_frame(input frame_t fr, output int cyc);
    done_delay = fr.delay; stall_len = fr.stall;
    cur_img_x = fr.x; cur_img_y = fr.y;
    passes = 0; taken = 0; last_x = 0; last_y = 0; last_f = 0;
    exp_q.delete();
    push_model(fr);
    for (int i = 0; i < 100 && !bus.cfg_ready; i++) @(negedge clk);
    check("cfg_ready_before_start", bus.cfg_ready, 1);
    bus.cfg_image_x_size = fr.x[ROW_BITS-1:0];
    bus.cfg_image_y_size = fr.y[COL_BITS-1:0];
    bus.cfg_step         = fr.step[FIXED_BITS-1:0];
    bus.cfg_inv_step     = fr.inv[FIXED_BITS-1:0];
    bus.cfg_start        = 1'b1;
    @(negedge clk);
    bus.cfg_start = 1'b0;
    @(negedge clk);
    cyc = 2;
    check("first_rs_start_latency", bus.rs_start, fr.levels > 0);
    check("empty_frame_done_latency", bus.cfg_done, fr.levels == 0);
  endtask

  task automatic finish_frame(input frame_t fr, input int cyc_in);
    int cyc;
    cyc = cyc_in;
    while (!bus.cfg_done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check("cfg_done_seen", bus.cfg_done, 1);
    check("cfg_levels", bus.cfg_levels, fr.levels);
    check("rs_passes", passes, fr.levels);
    check("rs_taken_pulses", taken, fr.levels);
    check("scoreboard_leftover", exp_q.size(), 0);
    check("last_target_x", last_x, fr.last_x);
    check("last_target_y", last_y, fr.last_y);
    check("last_factor", last_f, fr.last_f);
`ifdef RESIZE_PYRAMID_PERF_EN
    check("perf_cycles", bus.perf_cycles, cyc - 1);
`else
    check("perf_cycles_tied", bus.perf_cycles, 0);
`endif
    exp_q.delete();
    bus.cfg_taken = 1'b1;
    @(negedge clk);
    bus.cfg_taken = 1'b0;
    check("ready_after_taken", bus.cfg_ready, 1);
    check("done_after_taken", bus.cfg_done, 0);
    check("levels_held", bus.cfg_levels, fr.levels);
`ifdef RESIZE_PYRAMID_PERF_EN
    check("perf_cycles_held", bus.perf_cycles, cyc - 1);
`endif
  endtask

  task automatic run_frame(input frame_t fr);
    int cyc;
    start_frame(fr, cyc);
    finish_frame(fr, cyc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cfg_ready"},  bus.cfg_ready, 0);
    check({tag, "_cfg_done"},   bus.cfg_done, 0);
    check({tag, "_cfg_levels"}, bus.cfg_levels, 0);
    check({tag, "_rs_start"},   bus.rs_start, 0);
    check({tag, "_rs_taken"},   bus.rs_taken, 0);
    check({tag, "_image_x"},    bus.rs_image_x_size, 0);
    check({tag, "_target_x"},   bus.rs_target_x_size, 0);
    check({tag, "_target_y"},   bus.rs_target_y_size, 0);
    check({tag, "_factor"},     bus.rs_factor_x, 0);
    check({tag, "_lvl_valid"},  bus.lvl_valid, 0);
    check({tag, "_lvl_index"},  bus.lvl_index, 0);
    check({tag, "_perf"},       bus.perf_cycles, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t fr;
    //           x     y    step    inv    lv  lastx lasty lastf  delay stall
    frames[0] = '{320,  240, 'h140, 'h0CC, 10,  40,   29,  0,     3,    0};
    frames[1] = '{20,   240, 'h140, 'h0CC, 0,   0,    0,   0,     2,    0};
    frames[2] = '{1023, 1023,'h400, 'h0FF, 16,  963,  963, 65535, 2,    3};
    frames[3] = '{30,   30,  'h140, 'h0CC, 1,   30,   30,  256,   100,  0};
    frames[4] = '{240,  20,  'h140, 'h0CC, 0,   0,    0,   0,     2,    0};
    frames[5] = '{100,  100, 'h140, 'h100, 1,   100,  100, 256,   2,    0};
    frames[6] = '{24,   24,  'h140, 'h0CC, 1,   24,   24,  256,   2,    0};
    // 0x140^9 / 256^8 scaled: factors 256,320,400,500,625,781,976,1220,1525,1906
    frames[0].last_f = 1906;

    bus.cfg_start = 1'b0; bus.cfg_taken = 1'b0;
    bus.cfg_image_x_size = '0; bus.cfg_image_y_size = '0;
    bus.cfg_step = '0; bus.cfg_inv_step = '0;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    #1;
    check("ready_before_first_edge", bus.cfg_ready, 0);
    @(negedge clk);
    check("ready_after_release", bus.cfg_ready, 1);

    for (int i = 0; i < 7; i++) run_frame(frames[i]);

    // Consumer stalls on level 1; level 2 must not start early.
    hold_level = 1; hold_len = 50; hold_x = 255; hold_y = 191;
    run_frame(frames[0]);
    hold_level = -1;

    // Asynchronous reset while resize is busy on level 3.
    fr = frames[0];
    fr.delay = 20;
    begin
      int cyc;
      start_frame(fr, cyc);
    end
    for (int i = 0; i < 2000 && passes < 4; i++) @(negedge clk);
    check("reached_level3", passes, 4);
    repeat (2) @(negedge clk);
    check("wait_level3_index", bus.lvl_index, 3);
    check("wait_level3_rs_start", bus.rs_start, 0);
    #2 reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_before_edge_2", bus.cfg_ready, 0);
    @(negedge clk);
    check("ready_after_release_2", bus.cfg_ready, 1);
    run_frame(frames[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
